mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with fair tie-break
// and a per-access timeout that aborts stalled accesses with an error flag.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_valid,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_valid,
  output logic                      if_stall,
  output logic                      d_stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready,
  output logic                      err
);

  // state   | meaning
  // IDLE    | no access outstanding, arbitrate pending requests
  // IF_BUSY | fetch access outstanding on the memory port
  // D_BUSY  | load/store access outstanding on the memory port
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  localparam logic       FETCH    = 1'b0;
  localparam logic       DATA     = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic [7:0] tmo_cnt;
  logic       grant_if, grant_d, done, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        // On contention, data wins unless it had the previous grant.
        if (d_req && (!if_req || last_grant == FETCH)) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        timeout = !mem_ready && (tmo_cnt == TMO_LAST);
        done    = mem_ready || timeout;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_valid = (state == IF_BUSY) && done;
  assign d_valid  = (state == D_BUSY) && done;
  assign err      = timeout;
  assign if_rdata = (if_valid && mem_ready) ? mem_rdata : '0;
  assign d_rdata  = (d_valid && mem_ready) ? mem_rdata : '0;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= FETCH;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else if (grant_d) begin
      last_grant <= DATA;
      tmo_cnt    <= '0;
      mem_req    <= 1'b1;
      mem_we     <= d_we;
      mem_addr   <= d_addr;
      mem_wdata  <= d_wdata;
      mem_be     <= d_be;
    end else if (grant_if) begin
      last_grant <= FETCH;
      tmo_cnt    <= '0;
      mem_req    <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= if_addr;
      mem_wdata  <= '0;
      mem_be     <= '1;
    end else if (done) begin
      mem_req <= 1'b0;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses scored through a queue,
// plus hand sequences for contention, reset mid-access and dropped requests.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, if_stall, d_stall, mem_req, mem_we, err;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;      // ready in busy cycle delay+1; large = never
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_cycle;  // busy cycle carrying the valid pulse
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_access(input vec_t v);
    exp_t e;
    exp_t got;
    logic act_valid;
    @(posedge clk); #2;
    if_addr   = v.addr;
    d_addr    = v.addr;
    d_we      = v.we;
    d_wdata   = v.wdata;
    d_be      = v.be;
    if (v.is_d) d_req = 1'b1;
    else begin
      if_req  = 1'b1;
      d_we    = 1'b1;
      d_wdata = '1;
      d_be    = '0;
    end
    mem_ready = 1'b1;            // must be ignored while idle
    mem_rdata = 32'hFFFF_0000;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    #1;
    check("idle_mem_req", mem_req, 0);
    check("idle_ready_ignored", if_valid | d_valid, 0);
    check("idle_stall", v.is_d ? d_stall : if_stall, 1);
    for (int k = 1; k <= v.exp_cycle; k++) begin
      @(posedge clk); #2;
      mem_ready = (k == v.delay + 1);
      mem_rdata = mem_ready ? v.rdata : (32'hBAD0_0000 | 32'(k));
      #1;
      check("busy_mem_req", mem_req, 1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", mem_we, v.exp_we);
      check("mem_be", mem_be, v.exp_be);
      check("mem_wdata", mem_wdata, v.exp_wdata);
      act_valid = v.is_d ? d_valid : if_valid;
      check("valid", act_valid, k == v.exp_cycle);
      check("other_valid", v.is_d ? if_valid : d_valid, 0);
      check("stall", v.is_d ? d_stall : if_stall, k != v.exp_cycle);
      if (act_valid || k == v.exp_cycle) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_empty: valid with no expected entry at %0t", $time);
        end else begin
          got = sb.pop_front();
          check("rdata", v.is_d ? d_rdata : if_rdata, got.rdata);
          check("err", err, got.err);
          check("other_rdata", v.is_d ? if_rdata : d_rdata, 0);
        end
        break;
      end
    end
    @(posedge clk); #2;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("post_mem_req", mem_req, 0);
    check("post_valid", if_valid | d_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d, found;
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;

    tbl[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 2,  32'h00500093, 1'b0, 4'hF, 32'h0,        3, 1'b0, 32'h00500093};
    tbl[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 0,  32'h11112222, 1'b1, 4'hF, 32'hDEADBEEF, 1, 1'b0, 32'h11112222};
    tbl[2] = '{1'b1, 1'b0, 32'h3004, 32'h0,        4'h3, 1,  32'hCAFEF00D, 1'b0, 4'h3, 32'h0,        2, 1'b0, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 1'b0, 32'h3008, 32'h0,        4'hF, 99, 32'h55555555, 1'b0, 4'hF, 32'h0,        4, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h300C, 32'h0,        4'hC, 3,  32'h0BADF00D, 1'b0, 4'hC, 32'h0,        4, 1'b0, 32'h0BADF00D};
    tbl[5] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'h0, 99, 32'h77777777, 1'b0, 4'hF, 32'h0,        4, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h108,  32'h0,        4'h0, 3,  32'h00A00113, 1'b0, 4'hF, 32'h0,        4, 1'b0, 32'h00A00113};
    tbl[7] = '{1'b1, 1'b1, 32'h4000, 32'hA5A5A5A5, 4'h5, 2,  32'h13572468, 1'b1, 4'h5, 32'hA5A5A5A5, 3, 1'b0, 32'h13572468};

    // reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_valid_err", {if_valid, d_valid, err}, 0);

    // contention from reset: D, F, D, F with both requests held
    @(posedge clk); #2;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    #1;
    check("cont_idle_mem_req", mem_req, 0);
    check("cont_idle_stalls", {if_stall, d_stall}, 2'b11);
    for (int g = 0; g < 4; g++) begin
      exp_d = (g % 2 == 0);
      found = 1'b0;
      for (int w = 1; w <= 4 && !found; w++) begin
        @(posedge clk); #2;
        mem_ready = 1'b0;
        #1;
        if (mem_req) begin
          found = 1'b1;
          check("cont_spacing", w, (g == 0) ? 1 : 2);
          check("cont_mem_we", mem_we, exp_d);
          check("cont_mem_addr", mem_addr, exp_d ? 32'h2000 : 32'h400);
          mem_ready = 1'b1;
          mem_rdata = 32'h1000 + 32'(g);
          #1;
          check("cont_d_valid", d_valid, exp_d);
          check("cont_if_valid", if_valid, !exp_d);
          check("cont_rdata", exp_d ? d_rdata : if_rdata, 32'h1000 + 32'(g));
          check("cont_d_stall", d_stall, !exp_d);
          check("cont_if_stall", if_stall, exp_d);
        end else begin
          check("cont_wait_stalls", {if_stall, d_stall}, 2'b11);
        end
      end
      if (!found) begin
        n_vec++; n_err++;
        $display("FAIL cont_grant: no grant %0d within bound", g);
      end
    end
    @(posedge clk); #2;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("cont_end_mem_req", mem_req, 0);

    // single-access table
    for (int i = 0; i < 8; i++) run_access(tbl[i]);

    // reset while in D_BUSY
    @(posedge clk); #2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_be = 4'hF;
    @(posedge clk); #3;
    check("rstmid_busy", mem_req, 1);
    @(posedge clk); #2;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99999999;
    #1;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_no_valid", {d_valid, err}, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    @(posedge clk); #2;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("rstmid_release_idle", mem_req, 0);
    check("rstmid_d_stall", d_stall, 1);
    @(posedge clk); #3;
    check("rstmid_regrant", mem_req, 1);
    check("rstmid_regrant_addr", mem_addr, 32'h5000);
    mem_ready = 1'b1; mem_rdata = 32'h24682468;
    #1;
    check("rstmid_d_valid", d_valid, 1);
    check("rstmid_d_rdata", d_rdata, 32'h24682468);
    @(posedge clk); #2;
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("rstmid_end", mem_req, 0);

    // fetch request dropped mid-access still completes
    @(posedge clk); #2;
    if_req = 1'b1; if_addr = 32'h800;
    @(posedge clk); #2;
    if_req = 1'b0;
    #1;
    check("drop_mem_req", mem_req, 1);
    check("drop_mem_addr", mem_addr, 32'h800);
    check("drop_if_stall", if_stall, 0);
    @(posedge clk); #2;
    mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
    #1;
    check("drop_if_valid", if_valid, 1);
    check("drop_if_rdata", if_rdata, 32'h13579BDF);
    @(posedge clk); #2;
    mem_ready = 1'b0;
    #1;
    check("drop_end", {mem_req, if_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
